serial_adder: RTL and testbench

- Parametrised multi-bit adder that computes A + B + cin serially, DIGIT bits per clock, using one DIGIT-wide full-adder slice and a registered carry.
- Successor to the team's 1-bit full adder: generalised in width and digit size, with a start/busy/done handshake, held result registers and signed-overflow detection.
- Sits as an area-cheap arithmetic unit behind a simple controller. Trades latency for a single adder slice.

---
 rtl/serial_adder.sv | 163 ++++++++++++++++
 tb/tb_serial_adder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Serial adder: computes a + b + cin over WIDTH bits, DIGIT bits per clock,
// through a single DIGIT-wide adder slice and a registered carry.
// A start/busy/done handshake frames each operation. The result, unsigned
// carry-out and signed overflow are held until the next done pulse.
// WIDTH must be at least 2 and DIGIT must divide WIDTH exactly.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [WIDTH-1:0] r_aShift;
  logic [WIDTH-1:0] r_bShift;
  logic [WIDTH-1:0] r_resShift;
  logic             r_carry;
  logic             r_msbA;
  logic             r_msbB;
  logic [CW-1:0]    r_cnt;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_lastDigit;
  logic [DIGIT:0]   w_digitSum;
  logic [WIDTH-1:0] w_digitHigh;
  logic [WIDTH-1:0] w_resNext;

  // The one adder slice: low digit of each operand plus the running carry.
  // The new digit enters the result register from the MSB side, so after
  // N digits the first digit computed has reached the LSB position.
  assign w_digitSum  = {1'b0, r_aShift[DIGIT-1:0]}
                     + {1'b0, r_bShift[DIGIT-1:0]}
                     + (DIGIT+1)'(r_carry);
  assign w_digitHigh = WIDTH'(w_digitSum[DIGIT-1:0]) << (WIDTH - DIGIT);
  assign w_resNext   = (r_resShift >> DIGIT) | w_digitHigh;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: DONE accepts a new start just like IDLE, so
  // back-to-back operations run without a bubble cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    w_nextState = start ? RUN : IDLE;
      RUN:     w_nextState = w_lastDigit ? DONE : RUN;
      DONE:    w_nextState = start ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Control decode: when an operation is accepted, and when the digit
  // being added is the last one.
  always_comb begin
    w_accept    = 1'b0;
    w_lastDigit = 1'b0;
    case (r_state)
      IDLE:    w_accept = start;
      DONE:    w_accept = start;
      RUN:     w_lastDigit = (r_cnt == CW'(N - 1));
      default: begin
        w_accept    = 1'b0;
        w_lastDigit = 1'b0;
      end
    endcase
  end

  // Working registers: capture the operands on accept, then shift one
  // digit per RUN cycle. Once an operation is accepted, start is ignored
  // until DONE, so the captured operands stay put for the whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aShift   <= '0;
      r_bShift   <= '0;
      r_resShift <= '0;
      r_carry    <= 1'b0;
      r_msbA     <= 1'b0;
      r_msbB     <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_aShift   <= a;
      r_bShift   <= b;
      r_resShift <= '0;
      r_carry    <= cin;
      r_msbA     <= a[WIDTH-1];
      r_msbB     <= b[WIDTH-1];
      r_cnt      <= '0;
    end else if (r_state == RUN) begin
      r_aShift   <= r_aShift >> DIGIT;
      r_bShift   <= r_bShift >> DIGIT;
      r_resShift <= w_resNext;
      r_carry    <= w_digitSum[DIGIT];
      r_cnt      <= w_lastDigit ? '0 : r_cnt + 1'b1;
    end
  end

  // Held result: updated only on the edge that raises done. The overflow
  // term compares the operand signs with the sign of the final sum, which
  // already includes cin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_lastDigit) begin
      r_sum  <= w_resNext;
      r_cout <= w_digitSum[DIGIT];
      r_ovf  <= (r_msbA == r_msbB) && (w_resNext[WIDTH-1] != r_msbA);
    end
  end

  // Registered handshake: busy follows the state being entered, done
  // pulses for the single cycle spent in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_nextState == RUN);
      r_done <= w_lastDigit;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: table-driven vectors on 8-bit instances
// (DIGIT=1 and DIGIT=4), hand-written sequences for the multi-cycle corner
// cases, and an exhaustive sweep of 4-bit instances with DIGIT 1, 2 and 4.
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start81;
  logic       start84;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy81, done81, cout81, ovf81;
  logic [7:0] sum81;
  logic       busy84, done84, cout84, ovf84;
  logic [7:0] sum84;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic       busy41, done41, cout41, ovf41;
  logic [3:0] sum41;
  logic       busy42, done42, cout42, ovf42;
  logic [3:0] sum42;
  logic       busy44, done44, cout44, ovf44;
  logic [3:0] sum44;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] expSum;
    logic       expCout;
    logic       expOvf;
  } vec_t;

  vec_t vecs [12];

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut81 (
    .clk(clk), .rst(rst), .start(start81), .a(a8), .b(b8), .cin(cin8),
    .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .ovf(ovf81)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut84 (
    .clk(clk), .rst(rst), .start(start84), .a(a8), .b(b8), .cin(cin8),
    .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .ovf(ovf84)
  );

  serial_adder #(.WIDTH(4), .DIGIT(1)) dut41 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy41), .done(done41), .sum(sum41), .cout(cout41), .ovf(ovf41)
  );

  serial_adder #(.WIDTH(4), .DIGIT(2)) dut42 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy42), .done(done42), .sum(sum42), .cout(cout42), .ovf(ovf42)
  );

  serial_adder #(.WIDTH(4), .DIGIT(4)) dut44 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy44), .done(done44), .sum(sum44), .cout(cout44), .ovf(ovf44)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge, then settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation on the selected 8-bit instance (0: DIGIT=1,
  // 1: DIGIT=4), wait a bounded time for done, and check latency, the
  // busy window and the result visible in the done cycle.
  task automatic applyStimulus(input string name, input logic sel,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic [7:0] expSum,
                               input logic expCout, input logic expOvf);
    int   cycles;
    int   expLat;
    logic busyOk;
    logic curDone;
    logic curBusy;
    a8   = a;
    b8   = b;
    cin8 = c;
    if (sel) start84 = 1'b1;
    else     start81 = 1'b1;
    tick();
    start81 = 1'b0;
    start84 = 1'b0;
    expLat  = sel ? 2 : 8;
    cycles  = 0;
    busyOk  = 1'b1;
    curDone = sel ? done84 : done81;
    curBusy = sel ? busy84 : busy81;
    while (!curDone && cycles < 20) begin
      if (!curBusy) busyOk = 1'b0;
      tick();
      cycles++;
      curDone = sel ? done84 : done81;
      curBusy = sel ? busy84 : busy81;
    end
    checkOutput({name, "_latency"}, cycles, expLat);
    checkOutput({name, "_busyRun"}, busyOk, 1'b1);
    checkOutput({name, "_busyDone"}, curBusy, 1'b0);
    checkOutput({name, "_sum"}, sel ? sum84 : sum81, expSum);
    checkOutput({name, "_cout"}, sel ? cout84 : cout81, expCout);
    checkOutput({name, "_ovf"}, sel ? ovf84 : ovf81, expOvf);
  endtask

  initial begin
    int         doneCount;
    logic       doneSeen;
    logic [4:0] expFull;
    logic       expOvf4;

    testsRun    = 0;
    testsFailed = 0;
    rst     = 1'b1;
    start81 = 1'b0;
    start84 = 1'b0;
    start4  = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;

    vecs[0]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 8'h3C, 8'h0B, 1'b0, 8'h47, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    checkOutput("reset_d1", {busy81, done81, cout81, ovf81, sum81}, 32'h0);
    checkOutput("reset_d4", {busy84, done84, cout84, ovf84, sum84}, 32'h0);
    rst = 1'b0;
    tick();

    // Table-driven vectors; one idle cycle after each to see done drop
    for (int i = 0; i < 12; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b,
                    vecs[i].cin, vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf);
      tick();
      checkOutput($sformatf("vec%0d_doneDrop", i),
                  vecs[i].sel ? done84 : done81, 1'b0);
      checkOutput($sformatf("vec%0d_sumHeld", i),
                  vecs[i].sel ? sum84 : sum81, vecs[i].expSum);
    end

    // Start held high through the run with operands changed after capture
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start81 = 1'b1;
    tick();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done81) doneCount++;
    end
    start81 = 1'b0;
    checkOutput("held_doneCount", doneCount, 1);
    checkOutput("held_doneAtN", done81, 1'b1);
    checkOutput("held_sum", sum81, 8'h46);
    tick();
    checkOutput("held_idle", {busy81, done81}, 2'b00);

    // Back-to-back: second start accepted during the DONE cycle
    applyStimulus("b2b_first", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    applyStimulus("b2b_second", 1'b0, 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);
    tick();

    // Reset in the middle of a run: outputs clear at once, no done follows
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start81 = 1'b1;
    tick();
    start81 = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_d1", {busy81, done81, cout81, ovf81, sum81}, 32'h0);
    checkOutput("midreset_d4", {busy84, done84, cout84, ovf84, sum84}, 32'h0);
    tick();
    rst = 1'b0;
    doneSeen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done81 || busy81) doneSeen = 1'b1;
    end
    checkOutput("midreset_noDone", doneSeen, 1'b0);
    applyStimulus("afterReset", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    tick();

    // Exhaustive 4-bit sweep across DIGIT = 1, 2 and 4
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a4     = 4'(ai);
          b4     = 4'(bi);
          cin4   = 1'(ci);
          start4 = 1'b1;
          tick();
          start4 = 1'b0;
          for (int k = 0; k < 5; k++) tick();
          expFull = 5'(ai + bi + ci);
          expOvf4 = (a4[3] == b4[3]) && (expFull[3] != a4[3]);
          checkOutput($sformatf("w4d1_%0h_%0h_%0d", ai, bi, ci),
                      {cout41, sum41, ovf41}, {expFull, expOvf4});
          checkOutput($sformatf("w4d2_%0h_%0h_%0d", ai, bi, ci),
                      {cout42, sum42, ovf42}, {expFull, expOvf4});
          checkOutput($sformatf("w4d4_%0h_%0h_%0d", ai, bi, ci),
                      {cout44, sum44, ovf44}, {expFull, expOvf4});
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
